// File: rtl/sa_inst_issue_queue.sv
// Host instruction FIFO and one-at-a-time issue sequencer for the systolic array.
// Tracks the array idle flag for accept/complete, counts completions and flags accept timeouts.
module sa_inst_issue_queue #(
  parameter int unsigned          INST_BITS = 32,
  parameter int unsigned          DEPTH     = 8,
  parameter logic [INST_BITS-1:0] NOP       = '0,
  parameter int unsigned          TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INST_BITS-1:0]   in_inst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   issue_en,
  input  logic                   flush,
  output logic [INST_BITS-1:0]   sa_instruction,
  input  logic                   sa_idle,
  input  logic                   sa_flag,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic [15:0]            done_cnt,
  output logic                   last_flag,
  output logic                   err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_BUSY} state_t;

  state_t                state, state_n;
  logic [INST_BITS-1:0]  mem [DEPTH];
  logic [AW-1:0]         wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]         count_n;
  logic [TW-1:0]         timer, timer_n;
  logic [INST_BITS-1:0]  inst_n;
  logic [15:0]           done_n;
  logic                  flag_n, err_n;
  logic                  push, pop;

  // FIFO bookkeeping plus issue FSM; flush wins over a same-cycle push and blocks issue
  always_comb begin
    push     = in_valid && in_ready;
    pop      = (state == S_IDLE) && issue_en && (fifo_count != '0) && sa_idle && !flush;
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = fifo_count;
    timer_n  = timer;
    inst_n   = sa_instruction;
    done_n   = done_cnt;
    flag_n   = last_flag;
    err_n    = err_timeout;

    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + AW'(1);
      if (pop)  rd_ptr_n = rd_ptr + AW'(1);
      if (push && !pop)      count_n = fifo_count + CW'(1);
      else if (pop && !push) count_n = fifo_count - CW'(1);
    end

    case (state)
      S_IDLE: begin
        inst_n = NOP;
        if (pop) begin
          inst_n  = mem[rd_ptr];
          timer_n = '0;
          state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        timer_n = timer + TW'(1);
        if (!sa_idle) begin
          inst_n  = NOP;
          state_n = S_BUSY;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          inst_n  = NOP;
          state_n = S_IDLE;
        end
      end
      S_BUSY: begin
        inst_n = NOP;
        if (sa_idle) begin
          done_n  = done_cnt + 16'd1;
          flag_n  = sa_flag;
          state_n = S_IDLE;
        end
      end
      default: begin
        inst_n  = NOP;
        state_n = S_IDLE;
      end
    endcase
  end

  // Storage array carries no reset; only valid slots are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_inst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      in_ready       <= 1'b1;
      timer          <= '0;
      sa_instruction <= NOP;
      busy           <= 1'b0;
      done_cnt       <= '0;
      last_flag      <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_n;
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      fifo_count     <= count_n;
      in_ready       <= (count_n != CW'(DEPTH));
      timer          <= timer_n;
      sa_instruction <= inst_n;
      busy           <= (state_n != S_IDLE);
      done_cnt       <= done_n;
      last_flag      <= flag_n;
      err_timeout    <= err_n;
    end
  end

endmodule

// File: tb/tb_sa_inst_issue_queue.sv
// Directed bench for sa_inst_issue_queue: queue-based reference model checked every cycle,
// a small array responder, and hand-computed literal checks at key points.
module tb_sa_inst_issue_queue;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, in_valid, issue_en, flush, sa_idle, sa_flag;
  logic [31:0] in_inst;
  logic        in_ready, busy, last_flag, err_timeout;
  logic [31:0] sa_instruction;
  logic [3:0]  fifo_count;
  logic [15:0] done_cnt;

  int checks = 0;
  int failures = 0;

  sa_inst_issue_queue #(.INST_BITS(32), .DEPTH(DEPTH), .NOP(32'h0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_inst(in_inst), .in_valid(in_valid), .in_ready(in_ready),
    .issue_en(issue_en), .flush(flush), .sa_instruction(sa_instruction), .sa_idle(sa_idle),
    .sa_flag(sa_flag), .fifo_count(fifo_count), .busy(busy), .done_cnt(done_cnt),
    .last_flag(last_flag), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO as a queue, issue phase 0=idle 1=awaiting accept 2=executing
  logic [31:0] q[$];
  int          m_phase = 0;
  int          m_timer = 0;
  logic [31:0] m_inst = 0;
  int          m_done = 0;
  logic        m_flag = 0, m_err = 0;
  bit          model_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_phase = 0; m_timer = 0; m_inst = 0; m_done = 0; m_flag = 0; m_err = 0;
      model_valid = 1;
    end else if (model_valid) begin
      bit          do_push, do_pop;
      logic [31:0] head;
      do_push = in_valid && (q.size() != DEPTH);
      do_pop  = (m_phase == 0) && issue_en && (q.size() != 0) && sa_idle && !flush;
      head    = do_pop ? q[0] : 32'h0;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(in_inst);
      end
      if (m_phase == 0) begin
        if (do_pop) begin m_inst = head; m_timer = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (!sa_idle) begin m_phase = 2; m_inst = 0; end
        else if (m_timer == TIMEOUT - 1) begin m_err = 1; m_inst = 0; m_phase = 0; end
        else m_timer++;
      end else begin
        if (sa_idle) begin m_done = (m_done + 1) % 65536; m_flag = sa_flag; m_phase = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("sa_instruction", sa_instruction, m_inst);
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done_cnt", 32'(done_cnt), 32'(m_done));
      chk("last_flag", 32'(last_flag), 32'(m_flag));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
    end
  end

  // Array responder: drops idle 2 cycles after seeing an instruction, runs 5 cycles, flags on completion
  bit accept_en = 1;
  int ack_delay = 0;
  int busy_left = 0;

  initial begin
    sa_idle = 1'b1;
    sa_flag = 1'b0;
    forever begin
      tick();
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin sa_idle = 1'b1; sa_flag = 1'b1; end
      end else if (ack_delay > 0) begin
        ack_delay--;
        if (ack_delay == 0) begin sa_idle = 1'b0; sa_flag = 1'b0; busy_left = 5; end
      end else if (sa_instruction != 32'h0 && accept_en && sa_idle) begin
        ack_delay = 2;
      end
    end
  end

  initial begin
    int n, b;
    reset = 1'b1; in_valid = 1'b0; in_inst = 32'h0; issue_en = 1'b1; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_sa_instruction", sa_instruction, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    repeat (10) tick();
    chk("idle_done_cnt", 32'(done_cnt), 32'd0);

    // single issue
    in_valid = 1'b1; in_inst = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (done_cnt != 16'd1 && n < 60) begin tick(); n++; end
    chk("single_done_cnt", 32'(done_cnt), 32'd1);
    chk("single_last_flag", 32'(last_flag), 32'd1);
    chk("single_fifo_count", 32'(fifo_count), 32'd0);
    repeat (3) tick();

    // fill past capacity with issue paused
    issue_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_inst = 32'hB000_0001 + 32'(i);
      if (i == 8) chk("full_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("full_count", 32'(fifo_count), 32'd8);

    // pop and push offered in the same cycle at full
    issue_en = 1'b1; in_valid = 1'b1; in_inst = 32'hC000_0001;
    tick();
    chk("pp_count", 32'(fifo_count), 32'd7);
    chk("pp_head_issued", sa_instruction, 32'hB000_0001);
    tick();
    in_valid = 1'b0;
    chk("pp_refill_count", 32'(fifo_count), 32'd8);
    n = 0;
    while (done_cnt != 16'd10 && n < 300) begin tick(); n++; end
    chk("drain_done_cnt", 32'(done_cnt), 32'd10);
    chk("drain_count", 32'(fifo_count), 32'd0);

    // flush while an instruction is in flight
    issue_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'hD000_0001 + 32'(i);
      tick();
    end
    in_valid = 1'b0; issue_en = 1'b1;
    tick();
    issue_en = 1'b0;
    chk("fl_issued", sa_instruction, 32'hD000_0001);
    chk("fl_count_before", 32'(fifo_count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hE000_0001;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count_after", 32'(fifo_count), 32'd0);
    n = 0;
    while (done_cnt != 16'd11 && n < 60) begin tick(); n++; end
    chk("fl_done_cnt", 32'(done_cnt), 32'd11);
    repeat (2) tick();

    // acceptance timeout
    accept_en = 0;
    in_valid = 1'b1; in_inst = 32'hF000_0001; issue_en = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0; b = 0;
    while (!err_timeout && n < 100) begin
      tick(); n++;
      if (busy) b++;
    end
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_wait_cycles", 32'(b), 32'd16);
    chk("to_sa_instruction", sa_instruction, 32'h0);
    chk("to_done_cnt", 32'(done_cnt), 32'd11);
    repeat (10) tick();
    chk("to_sticky", 32'(err_timeout), 32'd1);

    // reset while the array is executing
    accept_en = 1;
    in_valid = 1'b1; in_inst = 32'h1234_0001;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (sa_idle && n < 20) begin tick(); n++; end
    tick();
    chk("rb_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rb_busy_after", 32'(busy), 32'd0);
    chk("rb_done_cnt", 32'(done_cnt), 32'd0);
    chk("rb_err", 32'(err_timeout), 32'd0);
    chk("rb_last_flag", 32'(last_flag), 32'd0);
    chk("rb_in_ready", 32'(in_ready), 32'd1);
    repeat (12) tick();
    chk("rb_done_stays", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
